perf_sample_streamer: RTL

//   Downstream consumer of performance_monitor outputs. On a periodic tick or a software

---
 rtl/perf_sample_streamer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/perf_sample_streamer.sv
// perf_sample_streamer
// Snapshots all performance_monitor metrics into shadow registers on a periodic
// tick or a software request. It then streams them as one framed record of
// 32-bit words over a valid/ready interface. The monitor itself is never touched.
module perf_sample_streamer #(
    parameter int unsigned NUM_CORES = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] total_instructions,
    input  logic [31:0] instructions_per_core [NUM_CORES],
    input  logic [31:0] l1i_hit_rate,
    input  logic [31:0] l1d_hit_rate,
    input  logic [31:0] l2_hit_rate,
    input  logic [31:0] avg_memory_latency,
    input  logic [31:0] noc_average_latency,
    input  logic [31:0] coherence_traffic_percentage,
    input  logic        enable,
    input  logic [31:0] sample_interval,
    input  logic        snapshot_req,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [7:0]  out_index,
    output logic        out_last,
    output logic        busy,
    output logic [15:0] dropped_count
);

    localparam int unsigned NUM_WORDS = 8 + NUM_CORES;
    localparam int unsigned IDX_W     = $clog2(NUM_WORDS);
    localparam logic [7:0]  NUM_WORDS_B = 8'(NUM_WORDS);
    localparam logic [IDX_W-1:0] LAST_PTR = IDX_W'(NUM_WORDS - 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t state, state_nxt;

    logic [31:0]      interval_cnt;
    logic             periodic_on;
    logic             tick;
    logic             trigger;
    logic [15:0]      seq;
    logic [IDX_W-1:0] word_ptr;
    logic             xfer;
    logic             xfer_last;
    logic             start;
    logic             drop;

    logic [31:0] capture [NUM_WORDS];
    logic [31:0] shadow  [NUM_WORDS];

    // Periodic sampling is live only with enable set and a non-zero interval.
    assign periodic_on = enable && (sample_interval != '0);
    // >= rather than == so that shrinking the interval below the running count still ticks.
    assign tick        = periodic_on && (interval_cnt >= (sample_interval - 32'd1));
    assign trigger     = tick || snapshot_req;

    // Record layout at the moment of capture: header, totals, per-core, cache/memory/NoC.
    assign capture[0] = {8'hA5, seq, NUM_WORDS_B};
    assign capture[1] = total_instructions;
    for (genvar g = 0; g < NUM_CORES; g++) begin : g_core_words
        assign capture[2 + g] = instructions_per_core[g];
    end
    assign capture[NUM_CORES + 2] = l1i_hit_rate;
    assign capture[NUM_CORES + 3] = l1d_hit_rate;
    assign capture[NUM_CORES + 4] = l2_hit_rate;
    assign capture[NUM_CORES + 5] = avg_memory_latency;
    assign capture[NUM_CORES + 6] = noc_average_latency;
    assign capture[NUM_CORES + 7] = coherence_traffic_percentage;

    // Handshake and status outputs derived from the FSM and the word pointer.
    assign out_valid = (state == SEND);
    assign busy      = (state == SEND);
    assign out_last  = (state == SEND) && (word_ptr == LAST_PTR);
    assign out_index = 8'(word_ptr);
    assign out_data  = (state == SEND) ? shadow[word_ptr] : '0;
    assign xfer      = out_valid && out_ready;
    assign xfer_last = xfer && (word_ptr == LAST_PTR);
    assign drop      = trigger && (state == SEND);

    // Interval counter: free-runs while periodic sampling is on, wraps on every tick.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            interval_cnt <= '0;
        end else if (!periodic_on || tick) begin
            interval_cnt <= '0;
        end else begin
            interval_cnt <= interval_cnt + 32'd1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: start a record on a trigger in IDLE, return after the last word moves.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        case (state)
            IDLE: begin
                if (trigger) begin
                    state_nxt = SEND;
                    start     = 1'b1;
                end
            end
            SEND: begin
                if (xfer_last) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Shadow capture, sequence numbering and word pointer advance.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow   <= '{default: '0};
            seq      <= '0;
            word_ptr <= '0;
        end else if (start) begin
            shadow   <= capture;
            seq      <= seq + 16'd1;
            word_ptr <= '0;
        end else if (xfer) begin
            word_ptr <= xfer_last ? '0 : (word_ptr + IDX_W'(1));
        end
    end

    // Count triggers lost while a record is in flight, saturating at all-ones.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dropped_count <= '0;
        end else if (drop && (dropped_count != '1)) begin
            dropped_count <= dropped_count + 16'd1;
        end
    end

endmodule
